// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI mode-3 slave endpoint running entirely in the sys_clk domain.
// The SPI pins are oversampled through synchronisers. MOSI is deframed into
// DATA_W-bit words and delivered on a valid/ready RX port. MISO is served from
// a one-deep TX holding register.
// Ports:
//   sys_clk, sys_rst_n         clock, synchronous active-low reset
//   spi_clk_i/cs_i/mosi_i      SPI pins from master (asynchronous)
//   spi_miso_o                 slave-out data
//   rx_data_o/valid_o/ready_i  received words; rx_overrun_o pulses when a word is dropped
//   tx_data_i/valid_i/ready_o  words to transmit; tx_underrun_o pulses when a word starts empty
//   busy_o                     synchronised chip select is low
// Optional: define SPI_SLAVE_ERRCNT_EN to add the saturating 16-bit ovr_cnt_o/udr_cnt_o counters.
module spi_slave_sync #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              busy_o
`ifdef SPI_SLAVE_ERRCNT_EN
  ,
  output logic [15:0]       ovr_cnt_o,
  output logic [15:0]       udr_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Pin synchronisers, preset to idle bus levels
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_dly_q, cs_dly_q, mosi_dly_q;
  logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;
  logic sck_s, cs_s, mosi_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edge pulses are registered; mosi_dly_q stays aligned with the sampled rise
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sck_sync_q  <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      mosi_dly_q  <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
      mosi_dly_q  <= mosi_s;
      sck_rise_q  <= sck_s & ~sck_dly_q;
      sck_fall_q  <= ~sck_s & sck_dly_q;
      cs_rise_q   <= cs_s & ~cs_dly_q;
      cs_fall_q   <= ~cs_s & cs_dly_q;
    end
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, hold_q, hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic tx_ready_q, tx_ready_d, miso_q, miso_d, rx_valid_q, rx_valid_d;
  logic rx_ovr_q, rx_ovr_d, tx_udr_q, tx_udr_d, busy_q, busy_d;
  logic [DATA_W-1:0] word, tx_src, tx_cur;
  logic              word_done;

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '1;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_udr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_udr_q   <= tx_udr_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: framing, shifting, RX delivery and TX holding register
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = 1'b0;
    tx_udr_d   = 1'b0;
    busy_d     = ~cs_s;
    word       = rx_sh_q;
    word_done  = 1'b0;
    tx_src     = '1;
    tx_cur     = tx_sh_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          // Frame ended: drop any partial word, keep the holding register
          state_d   = IDLE;
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          tx_sh_d   = '1;
        end else begin
          if (sck_fall_q) begin
            if (bit_cnt_q == '0) begin
              if (!tx_ready_q) begin
                tx_src     = hold_q;
                tx_ready_d = 1'b1;
              end else begin
                tx_udr_d = 1'b1;
              end
              tx_cur = tx_src;
            end
            // Shifter holds the bits still to be sent; vacated slots fill with ones
            if (MSB_FIRST) begin
              miso_d  = tx_cur[DATA_W-1];
              tx_sh_d = {tx_cur[DATA_W-2:0], 1'b1};
            end else begin
              miso_d  = tx_cur[0];
              tx_sh_d = {1'b1, tx_cur[DATA_W-1:1]};
            end
          end
          if (sck_rise_q) begin
            if (MSB_FIRST) begin
              word = {rx_sh_q[DATA_W-2:0], mosi_dly_q};
            end else begin
              word = {mosi_dly_q, rx_sh_q[DATA_W-1:1]};
            end
            rx_sh_d = word;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              word_done = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end

    // A new load wins over a same-cycle move into the shifter
    if (tx_valid_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end

    if (cs_s) begin
      miso_d = 1'b1;
    end
  end

  assign spi_miso_o    = miso_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_ovr_q;
  assign tx_ready_o    = tx_ready_q;
  assign tx_underrun_o = tx_udr_q;
  assign busy_o        = busy_q;

`ifdef SPI_SLAVE_ERRCNT_EN
  logic [15:0] ovr_cnt_q, udr_cnt_q;

  // Saturating error event counters
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ovr_cnt_q <= '0;
      udr_cnt_q <= '0;
    end else begin
      if (rx_ovr_q && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_q <= ovr_cnt_q + 16'd1;
      if (tx_udr_q && (udr_cnt_q != 16'hFFFF)) udr_cnt_q <= udr_cnt_q + 16'd1;
    end
  end

  assign ovr_cnt_o = ovr_cnt_q;
  assign udr_cnt_o = udr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed and randomized frames against a transaction-level model.
module tb_spi_slave_sync;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       spi_clk_i = 1'b1, spi_cs_i = 1'b1, spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_overrun_o, tx_ready_o, tx_underrun_o, busy_o;
  logic       rx_ready_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
`ifdef SPI_SLAVE_ERRCNT_EN
  logic [15:0] ovr_cnt_o, udr_cnt_o;
`endif

  spi_slave_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .spi_clk_i(spi_clk_i), .spi_cs_i(spi_cs_i), .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_overrun_o(rx_overrun_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_underrun_o(tx_underrun_o),
    .busy_o(busy_o)
`ifdef SPI_SLAVE_ERRCNT_EN
    , .ovr_cnt_o(ovr_cnt_o), .udr_cnt_o(udr_cnt_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation: cycle stamp, accepted words, error pulses
  int         cyc = 0;
  logic [7:0] got_rx[$];
  int         got_ovr = 0, got_udr = 0;
  logic       prev_valid = 1'b0;
  int         valid_rise_cyc = 0;
  int         last_rise_cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (rx_valid_o === 1'b1 && rx_ready_i === 1'b1) got_rx.push_back(rx_data_o);
    if (rx_overrun_o === 1'b1) got_ovr++;
    if (tx_underrun_o === 1'b1) got_udr++;
    if (rx_valid_o === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
    prev_valid = rx_valid_o;
  end

  // Reference model state
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic       m_hold_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       m_pend = 1'b0;
  logic [7:0] m_pend_data = 8'h00;
  int         exp_ovr = 0, exp_udr = 0, ovr_base = 0, udr_base = 0;

  // Master side
  logic [7:0] m_words[$];
  logic [7:0] rd_words[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic tx_load(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    m_hold      = d;
    m_hold_full = 1'b1;
    check_eq("tx_ready after load", 32'(tx_ready_o), 32'd0);
  endtask

  // Mode-3 master; stop_after>0 returns mid-frame with cs still low
  task automatic spi_frame(input int stop_after);
    int sent;
    logic [7:0] w, r;
    sent = 0;
    rd_words.delete();
    spi_cs_i = 1'b0;
    tick(HALF);
    foreach (m_words[k]) begin
      w = m_words[k];
      r = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        spi_clk_i  = 1'b0;
        spi_mosi_i = w[b];
        tick(HALF);
        r[b] = spi_miso_o;
        spi_clk_i = 1'b1;
        last_rise_cyc = cyc;
        tick(HALF);
        sent++;
        if (stop_after != 0 && sent == stop_after) return;
      end
      rd_words.push_back(r);
    end
    spi_cs_i = 1'b1;
    tick(2 * HALF);
  endtask

  // Expected outcome of a frame where `bits` sclk rises happened
  task automatic model_frame(input int bits);
    logic [7:0] mo;
    foreach (m_words[k]) begin
      if (k * 8 < bits) begin
        if (m_hold_full) begin
          mo = m_hold;
          m_hold_full = 1'b0;
        end else begin
          mo = 8'hFF;
          exp_udr++;
        end
        if ((k + 1) * 8 <= bits) begin
          exp_miso.push_back(mo);
          if (rx_ready_i) exp_rx.push_back(m_words[k]);
          else if (!m_pend) begin
            m_pend = 1'b1;
            m_pend_data = m_words[k];
          end else exp_ovr++;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, " rx count"}, 32'(got_rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
      check_eq($sformatf("%s rx[%0d]", tag, i), 32'(got_rx[i]), 32'(exp_rx[i]));
    check_eq({tag, " miso count"}, 32'(rd_words.size()), 32'(exp_miso.size()));
    for (int i = 0; i < rd_words.size() && i < exp_miso.size(); i++)
      check_eq($sformatf("%s miso[%0d]", tag, i), 32'(rd_words[i]), 32'(exp_miso[i]));
    check_eq({tag, " underruns"}, 32'(got_udr), 32'(exp_udr));
    check_eq({tag, " overruns"}, 32'(got_ovr), 32'(exp_ovr));
    check_eq({tag, " tx_ready"}, 32'(tx_ready_o), 32'(!m_hold_full));
    check_eq({tag, " idle miso"}, 32'(spi_miso_o), 32'd1);
    check_eq({tag, " idle busy"}, 32'(busy_o), 32'd0);
`ifdef SPI_SLAVE_ERRCNT_EN
    check_eq({tag, " ovr_cnt"}, 32'(ovr_cnt_o), 32'(exp_ovr - ovr_base));
    check_eq({tag, " udr_cnt"}, 32'(udr_cnt_o), 32'(exp_udr - udr_base));
`endif
    got_rx.delete();
    exp_rx.delete();
    exp_miso.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " miso"}, 32'(spi_miso_o), 32'd1);
    check_eq({tag, " rx_data"}, 32'(rx_data_o), 32'd0);
    check_eq({tag, " rx_valid"}, 32'(rx_valid_o), 32'd0);
    check_eq({tag, " rx_overrun"}, 32'(rx_overrun_o), 32'd0);
    check_eq({tag, " tx_ready"}, 32'(tx_ready_o), 32'd1);
    check_eq({tag, " tx_underrun"}, 32'(tx_underrun_o), 32'd0);
    check_eq({tag, " busy"}, 32'(busy_o), 32'd0);
`ifdef SPI_SLAVE_ERRCNT_EN
    check_eq({tag, " ovr_cnt"}, 32'(ovr_cnt_o), 32'd0);
    check_eq({tag, " udr_cnt"}, 32'(udr_cnt_o), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with idle pins
    sys_rst_n = 1'b0;
    tick(3);
    check_reset_vals("reset");
    sys_rst_n = 1'b1;
    tick(2);
    check_eq("post-reset tx_ready", 32'(tx_ready_o), 32'd1);

    // Single word, with RX latency measured from the last sclk rise
    tx_load(8'h3C);
    m_words = '{8'hA5};
    spi_frame(0);
    model_frame(8);
    check_eq("latency", 32'(valid_rise_cyc - last_rise_cyc), 32'(SYNC_STAGES + 2));
    check_eq("single rx_data held", 32'(rx_data_o), 32'hA5);
    check_eq("single rx_valid low", 32'(rx_valid_o), 32'd0);
    check_frame("single");

    // Back-to-back words, second one underruns
    tx_load(8'h12);
    m_words = '{8'h81, 8'h7E};
    spi_frame(0);
    model_frame(16);
    check_frame("b2b");

    // Overrun with the consumer stalled
    rx_ready_i = 1'b0;
    m_words = '{8'h11, 8'h22};
    spi_frame(0);
    model_frame(16);
    check_eq("ovr rx_valid", 32'(rx_valid_o), 32'd1);
    check_eq("ovr rx_data", 32'(rx_data_o), 32'(m_pend_data));
    rx_ready_i = 1'b1;
    exp_rx.push_back(m_pend_data);
    m_pend = 1'b0;
    tick(3);
    check_frame("overrun");

    // Abort after 5 bits, then a clean frame
    m_words = '{8'hFF};
    spi_frame(5);
    model_frame(5);
    tick(HALF);
    spi_cs_i = 1'b1;
    tick(2 * HALF);
    check_eq("abort rx_valid", 32'(rx_valid_o), 32'd0);
    check_frame("abort");
    m_words = '{8'h5A};
    spi_frame(0);
    model_frame(8);
    check_frame("after abort");

    // Reset mid-frame after 3 bits
    tx_load(8'h66);
    m_words = '{8'hC3};
    spi_frame(3);
    model_frame(3);
    sys_rst_n = 1'b0;
    tick(3);
    check_reset_vals("mid reset");
    sys_rst_n = 1'b1;
    m_hold_full = 1'b0;
    m_pend = 1'b0;
    ovr_base = exp_ovr;
    udr_base = exp_udr;
    tick(4);
    spi_cs_i = 1'b1;
    spi_mosi_i = 1'b0;
    tick(2 * HALF);
    check_frame("mid reset frame");
    tx_load(8'h96);
    m_words = '{8'hC3};
    spi_frame(0);
    model_frame(8);
    check_frame("after reset");

    // Randomized frames
    for (int f = 0; f < 15; f++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      m_words.delete();
      for (int i = 0; i < nw; i++) m_words.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) tx_load(8'($urandom));
      spi_frame(0);
      model_frame(nw * 8);
      check_frame($sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
